// File: rtl/paint_scan_ctrl.sv
// Raster scheduler: sweeps paint_x/paint_y through one frame, tracks renderer latency with a credit-guarded color FIFO.
// Optional PAINT_SCAN_FRAME_CNT_EN adds a 16-bit completed-frame counter on frame_cnt (tied to 0 otherwise).
module paint_scan_ctrl #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 480,
  parameter int LATENCY    = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               frame_start,
  output logic signed [15:0] paint_x,
  output logic signed [15:0] paint_y,
  input  logic [15:0]        paint_color,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [15:0]        pix_data,
  output logic               pix_first,
  output logic               pix_last,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_cnt
);

  localparam int XW  = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW  = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int CW  = $clog2(LATENCY + FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [LATENCY-1:0] validSr_q, validSr_d;
  logic [LATENCY-1:0] firstSr_q, firstSr_d;
  logic [LATENCY-1:0] lastSr_q, lastSr_d;
  logic [15:0]        dataMem_q [FIFO_DEPTH];
  logic               firstMem_q [FIFO_DEPTH];
  logic               lastMem_q [FIFO_DEPTH];
  logic [PW-1:0]      wrPtr_q, rdPtr_q;
  logic [FCW-1:0]     fifoCnt_q;
  logic               frameDone_q;

  logic [CW-1:0]      inflightCnt;
  logic               issue, xLast, yLast;
  logic               fifoPush, fifoPop, lastPop;

  assign xLast = (x_q == XW'(H_RES - 1));
  assign yLast = (y_q == YW'(V_RES - 1));

  always_comb begin
    inflightCnt = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflightCnt = inflightCnt + CW'(validSr_q[i]);
    end
  end

  // Credit: every issued coordinate owns a FIFO slot until its pixel is popped.
  assign issue    = (state_q == SCAN) &&
                    ((inflightCnt + CW'(fifoCnt_q)) < CW'(FIFO_DEPTH));
  assign fifoPush = validSr_q[LATENCY-1];
  assign fifoPop  = pix_valid && pix_ready;
  assign lastPop  = fifoPop && lastMem_q[rdPtr_q];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = SCAN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      SCAN: begin
        if (issue) begin
          if (xLast) begin
            if (yLast) begin
              state_d = DRAIN;
            end else begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      DRAIN: begin
        if (lastPop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    validSr_d    = '0;
    firstSr_d    = '0;
    lastSr_d     = '0;
    validSr_d[0] = issue;
    firstSr_d[0] = issue && (x_q == '0) && (y_q == '0);
    lastSr_d[0]  = issue && xLast && yLast;
    for (int i = 1; i < LATENCY; i++) begin
      validSr_d[i] = validSr_q[i-1];
      firstSr_d[i] = firstSr_q[i-1];
      lastSr_d[i]  = lastSr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      validSr_q   <= '0;
      firstSr_q   <= '0;
      lastSr_q    <= '0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      validSr_q   <= validSr_d;
      firstSr_q   <= firstSr_d;
      lastSr_q    <= lastSr_d;
      frameDone_q <= (state_q == DRAIN) && lastPop;
    end
  end

  // Head is read straight from storage so it stays put while the writer stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      fifoCnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        dataMem_q[i]  <= '0;
        firstMem_q[i] <= 1'b0;
        lastMem_q[i]  <= 1'b0;
      end
    end else begin
      if (fifoPush) begin
        dataMem_q[wrPtr_q]  <= paint_color;
        firstMem_q[wrPtr_q] <= firstSr_q[LATENCY-1];
        lastMem_q[wrPtr_q]  <= lastSr_q[LATENCY-1];
        wrPtr_q             <= wrPtr_q + PW'(1);
      end
      if (fifoPop) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      case ({fifoPush, fifoPop})
        2'b10:   fifoCnt_q <= fifoCnt_q + FCW'(1);
        2'b01:   fifoCnt_q <= fifoCnt_q - FCW'(1);
        default: fifoCnt_q <= fifoCnt_q;
      endcase
    end
  end

`ifdef PAINT_SCAN_FRAME_CNT_EN
  logic [15:0] frameCnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frameCnt_q <= '0;
    end else if ((state_q == DRAIN) && lastPop) begin
      frameCnt_q <= frameCnt_q + 16'd1;
    end
  end

  assign frame_cnt = frameCnt_q;
`else
  assign frame_cnt = '0;
`endif

  assign paint_x    = 16'(x_q);
  assign paint_y    = 16'(y_q);
  assign pix_valid  = (fifoCnt_q != '0);
  assign pix_data   = dataMem_q[rdPtr_q];
  assign pix_first  = firstMem_q[rdPtr_q];
  assign pix_last   = lastMem_q[rdPtr_q];
  assign busy       = (state_q != IDLE);
  assign frame_done = frameDone_q;

endmodule
